// File: rtl/xadc_drp_arb_pkg.sv
// Shared XADC DRP definitions: bus widths, status register addresses and the
// arbiter state encoding, used by the arbiter and the ADC front-end.
package xadc_drp_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  localparam logic [DRP_AW-1:0] ADDR_TEMP = 7'h00;
  localparam logic [DRP_AW-1:0] ADDR_VCCINT = 7'h01;
  localparam logic [DRP_AW-1:0] ADDR_AUX6 = 7'h16;
  localparam logic [DRP_AW-1:0] ADDR_CFG0 = 7'h40;
  localparam logic [DRP_AW-1:0] ADDR_CFG1 = 7'h41;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } drp_state_e;

endpackage

// File: rtl/xadc_drp_arb_if.sv
// Requester-side and XADC DRP-side signal bundle of the DRP arbiter.
// The slave modport is the arbiter view, master is the surrounding system.
interface xadc_drp_arb_if #(
  parameter int N_REQ = 4
);
  import xadc_drp_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*DRP_AW-1:0] addr;
  logic [N_REQ*DRP_DW-1:0] wdata;
  logic [N_REQ-1:0]        pend;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        err;
  logic [DRP_DW-1:0]       rdata;

  logic [DRP_AW-1:0]       daddr;
  logic                    den;
  logic                    dwe;
  logic [DRP_DW-1:0]       di;
  logic [DRP_DW-1:0]       do_drp;
  logic                    drdy;

  modport slave (
    input  req, we, addr, wdata, do_drp, drdy,
    output pend, ack, err, rdata, daddr, den, dwe, di
  );

  modport master (
    output req, we, addr, wdata, do_drp, drdy,
    input  pend, ack, err, rdata, daddr, den, dwe, di
  );

endinterface

// File: rtl/xadc_drp_arb_rr_pick.sv
// Combinational round-robin selector: first pending requester after 'last',
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last) + k) % N_REQ);
      if (!valid && pend[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_arb.sv
// Round-robin arbiter sharing one XADC DRP port among N_REQ requesters.
// Define XADC_DRP_ARB_TIMEOUT_EN to abort a WAIT without drdy after TIMEOUT cycles.
module xadc_drp_arb
  import xadc_drp_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  xadc_drp_arb_if.slave bus
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("xadc_drp_arb: N_REQ must be 2..8 and TIMEOUT at least 1");
  end

  drp_state_e        state;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     last;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic [N_REQ-1:0]  pend;
  logic [N_REQ-1:0]  ack;
  logic [N_REQ-1:0]  err_now;
  logic [N_REQ-1:0]  cap;
  logic              den;
  logic              dwe;
  logic [DRP_AW-1:0] daddr;
  logic [DRP_DW-1:0] di;
  logic [DRP_DW-1:0] rdata;

  logic [N_REQ-1:0]  hold_we;
  logic [DRP_AW-1:0] hold_addr  [N_REQ];
  logic [DRP_DW-1:0] hold_wdata [N_REQ];

`ifdef XADC_DRP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [N_REQ-1:0] err_q;
  logic [CW-1:0]    cnt;
  assign err_now = err_q;
`else
  assign err_now = '0;
`endif

  // A strobe is taken when idle, or when it lands on its own completion cycle.
  always_comb begin
    cap = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cap[i] = bus.req[i] && (!pend[i] || ack[i] || err_now[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (cap[i]) begin
        hold_we[i]    <= bus.we[i];
        hold_addr[i]  <= bus.addr[DRP_AW*i +: DRP_AW];
        hold_wdata[i] <= bus.wdata[DRP_DW*i +: DRP_DW];
      end
    end
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .pend   (pend),
    .last   (last),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      winner <= '0;
      last   <= IW'(N_REQ - 1);
      pend   <= '0;
      ack    <= '0;
      den    <= 1'b0;
      dwe    <= 1'b0;
      daddr  <= '0;
      di     <= '0;
      rdata  <= '0;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
      err_q  <= '0;
      cnt    <= '0;
`endif
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cap[i]) begin
          pend[i] <= 1'b1;
        end else if (ack[i] || err_now[i]) begin
          pend[i] <= 1'b0;
        end
      end

      ack <= '0;
      den <= 1'b0;
      dwe <= 1'b0;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
      err_q <= '0;
`endif

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            winner <= pick_idx;
            den    <= 1'b1;
            dwe    <= hold_we[pick_idx];
            daddr  <= hold_addr[pick_idx];
            di     <= hold_wdata[pick_idx];
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef XADC_DRP_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.drdy) begin
            if (!hold_we[winner]) begin
              rdata <= bus.do_drp;
            end
            last        <= winner;
            ack[winner] <= 1'b1;
            state       <= ST_DONE;
          end
`ifdef XADC_DRP_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            last          <= winner;
            err_q[winner] <= 1'b1;
            state         <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pend  = pend;
  assign bus.ack   = ack;
  assign bus.err   = err_now;
  assign bus.rdata = rdata;
  assign bus.daddr = daddr;
  assign bus.den   = den;
  assign bus.dwe   = dwe;
  assign bus.di    = di;

endmodule

// File: doc/xadc_drp_arb.md
XADC_DRP_ARB -- requirements
Module: xadc_drp_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of DRP requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, the number of cycles spent in WAIT without drdy before abort.
REQ-003 The block SHALL have port clk, input, 1, the single clock, also driving the XADC DCLK.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port req, input, N_REQ, a one-cycle request strobe per requester.
REQ-006 The block SHALL have port we, input, N_REQ, per requester: 1 = write, 0 = read; sampled with req.
REQ-007 The block SHALL have port addr, input, N_REQ*7, DRP address per requester, flattened with requester i at [7i+6:7i]; sampled with req.
REQ-008 The block SHALL have port wdata, input, N_REQ*16, write data per requester, flattened with requester i at [16i+15:16i]; sampled with req.
REQ-009 The block SHALL have port pend, output, N_REQ, per requester: request captured and not yet completed.
REQ-010 The block SHALL have port ack, output, N_REQ, a one-cycle pulse marking successful completion.
REQ-011 The block SHALL have port err, output, N_REQ, a one-cycle pulse marking a timeout abort.
REQ-012 The block SHALL have port rdata, output, 16, the read result; valid while ack is high for a read.
REQ-013 The block SHALL have ports daddr (output, 7), den (output, 1), dwe (output, 1), di (output, 16), do_drp (input, 16) and drdy (input, 1): the XADC DRP port.

Function
REQ-014 The block SHALL set pend[i] on any cycle where req[i]=1 and pend[i]=0, capturing we[i], addr[i] and wdata[i] into requester-i holding registers.
REQ-015 The block SHALL ignore a req[i] strobe that arrives while pend[i]=1: no state change, holding registers unchanged.
REQ-016 The block SHALL clear pend[i] in the cycle ack[i] or err[i] is high, unless req[i] is high in that same cycle; a new strobe wins and re-captures.
REQ-017 The block SHALL implement the states IDLE, ISSUE, WAIT and DONE.
REQ-018 In IDLE with any pend set, the block SHALL grant round-robin, searching from (last+1) mod N_REQ, latch the winner, and go to ISSUE; with no pend set it SHALL remain in IDLE.
REQ-019 In ISSUE, for exactly one cycle, the block SHALL drive den=1, dwe=winner's we, daddr=winner's addr and di=winner's wdata, then go to WAIT.
REQ-020 Outside ISSUE the block SHALL hold den=0 and dwe=0; daddr and di SHALL hold their last values.
REQ-021 In WAIT on drdy=1, the block SHALL register rdata<=do_drp for a read (rdata unchanged for a write), set last=winner, and go to DONE.
REQ-022 In DONE the block SHALL pulse ack[winner] for one cycle, then go to IDLE.
REQ-023 Minimum latency SHALL be: pend visible at T+1 for a strobe at T; den at T+2; with drdy at T+3, ack at T+4.
REQ-024 The block SHALL ignore drdy in IDLE, ISSUE and DONE.
REQ-025 The block SHALL allow at most one DRP transaction outstanding.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL force state IDLE; pend, ack, err, den and dwe to 0; rdata, daddr and di to 0; last to N_REQ-1 so that requester 0 has first priority.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no ack or err, and SHALL discard all pending requests.

Configuration
REQ-028 With XADC_DRP_ARB_TIMEOUT_EN defined, a cycle counter SHALL clear on WAIT entry; on reaching TIMEOUT with no drdy, the block SHALL go to DONE, pulse err[winner] instead of ack, and leave rdata unchanged.
REQ-029 Without XADC_DRP_ARB_TIMEOUT_EN, WAIT SHALL be exited only by drdy, err SHALL be constant 0, and no counter SHALL be synthesized.

Structure
REQ-030 A package xadc_drp_pkg SHALL hold the state enum, DRP_AW=7, DRP_DW=16, and the status register address constants (e.g. 7'h16 aux channel 6, 7'h40 config reg 0), shared with the ADC front-end.
REQ-031 The round-robin selector SHALL be a combinational sub-module rr_pick (inputs pend and last; outputs winner index and valid).

Verification
REQ-032 Single read: req[0] with addr 7'h16 at T, drdy and do_drp=16'hABC0 at T+3 -> den=1/dwe=0 only at T+2; ack[0] and rdata=16'hABC0 at T+4.
REQ-033 Write: req[1] with we=1, addr 7'h40, wdata 16'h3016 -> di=16'h3016, daddr=7'h40, dwe=1 for one cycle; ack[1] follows drdy by 1 cycle; rdata unchanged.
REQ-034 Fairness: all four req strobed together, drdy 2 cycles after each den -> grant order 0,1,2,3; with 0 and 2 re-strobed on ack, order continues 0,2.
REQ-035 Collision: req[0] strobed while pend[0]=1 -> ignored and holding regs unchanged; req[0] strobed in the ack[0] cycle -> pend[0] stays 1 and a new transaction is issued.
REQ-036 Timeout (macro defined, TIMEOUT=8): drdy withheld -> err[winner] pulses; no ack; the next requester is then served normally. Macro undefined -> the block waits indefinitely.
REQ-037 Reset in WAIT: rst pulsed one cycle -> den=0, all pend=0, and no ack/err; a late drdy is ignored.
